// File: rtl/armleocpu_div_sequencer_if.sv
// Request/response and divider-side signals of the divide sequencer.
// slave: sequencer side; master: execute stage plus divider.
interface armleocpu_div_sequencer_if;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        req_kill;
  logic        resp_valid;
  logic [31:0] resp_result;
  logic        div_fetch;
  logic [31:0] div_dividend;
  logic [31:0] div_divisor;
  logic        div_ready;
  logic        div_division_by_zero;
  logic [31:0] div_quotient;
  logic [31:0] div_remainder;

  modport slave (
    input  req_valid, req_op, req_a, req_b, req_kill,
    input  div_ready, div_division_by_zero,
    input  div_quotient, div_remainder,
    output req_ready, resp_valid, resp_result,
    output div_fetch, div_dividend, div_divisor
  );

  modport master (
    output req_valid, req_op, req_a, req_b, req_kill,
    output div_ready, div_division_by_zero,
    output div_quotient, div_remainder,
    input  req_ready, resp_valid, resp_result,
    input  div_fetch, div_dividend, div_divisor
  );
endinterface

// File: rtl/armleocpu_div_sequencer.sv
// DIV/DIVU/REM/REMU front-end for the iterative unsigned divider:
// sign handling, RISC-V special cases, kill/drain of in-flight ops.
module armleocpu_div_sequencer (
  input logic                        clk,
  input logic                        rst,
  armleocpu_div_sequencer_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DRAIN
  } state_t;

  state_t      state_q, state_d;
  logic        rem_q, rem_d;
  logic        sign_a_q, sign_a_d;
  logic        sign_b_q, sign_b_d;
  logic        fetch_q, fetch_d;
  logic        valid_q, valid_d;
  logic [31:0] result_q, result_d;
  logic [31:0] dividend_q, dividend_d;
  logic [31:0] divisor_q, divisor_d;

  logic        signed_op;
  logic        sa_in;
  logic        sb_in;
  logic        b_zero;
  logic        ovf;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [31:0] sel;
  logic        neg;
  logic [31:0] val;
  logic [31:0] dz_res;

  assign signed_op = ~bus.req_op[0];
  assign sa_in     = signed_op & bus.req_a[31];
  assign sb_in     = signed_op & bus.req_b[31];
  assign b_zero    = (bus.req_b == 32'h0);
  assign ovf       = signed_op
                   & (bus.req_a == 32'h8000_0000)
                   & (bus.req_b == 32'hFFFF_FFFF);
  assign mag_a     = sa_in ? -bus.req_a : bus.req_a;
  assign mag_b     = sb_in ? -bus.req_b : bus.req_b;

  // Remainder takes the dividend's sign, quotient the xor of both.
  assign sel    = rem_q ? bus.div_remainder : bus.div_quotient;
  assign neg    = rem_q ? sign_a_q : (sign_a_q ^ sign_b_q);
  assign val    = neg ? -sel : sel;
  assign dz_res = rem_q
                ? (sign_a_q ? -dividend_q : dividend_q)
                : 32'hFFFF_FFFF;

  assign bus.req_ready    = (state_q == S_IDLE) & ~rst;
  assign bus.resp_valid   = valid_q;
  assign bus.resp_result  = result_q;
  assign bus.div_fetch    = fetch_q;
  assign bus.div_dividend = dividend_q;
  assign bus.div_divisor  = divisor_q;

  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    sign_a_d   = sign_a_q;
    sign_b_d   = sign_b_q;
    fetch_d    = 1'b0;
    valid_d    = 1'b0;
    result_d   = result_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.req_valid && !bus.req_kill) begin
          rem_d    = bus.req_op[1];
          sign_a_d = sa_in;
          sign_b_d = sb_in;
          if (b_zero) begin
            valid_d  = 1'b1;
            result_d = bus.req_op[1] ? bus.req_a : 32'hFFFF_FFFF;
          end else if (ovf) begin
            valid_d  = 1'b1;
            result_d = bus.req_op[1] ? 32'h0 : 32'h8000_0000;
          end else begin
            dividend_d = mag_a;
            divisor_d  = mag_b;
            fetch_d    = 1'b1;
            state_d    = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        // A kill coinciding with completion needs no drain.
        if (bus.req_kill) begin
          state_d = bus.div_ready ? S_IDLE : S_DRAIN;
        end else if (bus.div_ready) begin
          valid_d  = 1'b1;
          result_d = bus.div_division_by_zero ? dz_res : val;
          state_d  = S_IDLE;
        end
      end
      S_DRAIN: begin
        if (bus.div_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      rem_q      <= 1'b0;
      sign_a_q   <= 1'b0;
      sign_b_q   <= 1'b0;
      fetch_q    <= 1'b0;
      valid_q    <= 1'b0;
      result_q   <= 32'h0;
      dividend_q <= 32'h0;
      divisor_q  <= 32'h0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      sign_a_q   <= sign_a_d;
      sign_b_q   <= sign_b_d;
      fetch_q    <= fetch_d;
      valid_q    <= valid_d;
      result_q   <= result_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
    end
  end

endmodule

// File: tb/tb_armleocpu_div_sequencer.sv
// Directed bench for armleocpu_div_sequencer; the bench plays the
// execute stage and the divider, with hand-computed expectations.
module tb_armleocpu_div_sequencer;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  armleocpu_div_sequencer_if bus ();

  armleocpu_div_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    repeat (2) @(negedge clk);
    vectors++;
    if (bus.req_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_req_ready got %b want 0", bus.req_ready);
    end
    vectors++;
    if (bus.resp_valid !== 1'b0 || bus.resp_result !== 32'h0) begin
      miscompares++;
      $display("FAIL rst_resp got %b/%h want 0/0",
               bus.resp_valid, bus.resp_result);
    end
    vectors++;
    if (bus.div_fetch !== 1'b0 || bus.div_dividend !== 32'h0 ||
        bus.div_divisor !== 32'h0) begin
      miscompares++;
      $display("FAIL rst_div got %b/%h/%h want 0/0/0", bus.div_fetch,
               bus.div_dividend, bus.div_divisor);
    end
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (bus.req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_release_ready got %b want 1", bus.req_ready);
    end
  endtask

  task automatic do_normal(input logic [1:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] dd,
                           input logic [31:0] ds, input logic [31:0] q,
                           input logic [31:0] r, input logic [31:0] res,
                           input int lat, input string name);
    int extra;
    extra = 0;
    vectors++;
    if (bus.req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL %s ready_in got %b want 1", name, bus.req_ready);
    end
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
    bus.req_valid = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b0;
    vectors++;
    if (bus.div_fetch !== 1'b1 || bus.req_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL %s fetch/ready got %b/%b want 1/0", name,
               bus.div_fetch, bus.req_ready);
    end
    vectors++;
    if (bus.div_dividend !== dd || bus.div_divisor !== ds) begin
      miscompares++;
      $display("FAIL %s operands got %h/%h want %h/%h", name,
               bus.div_dividend, bus.div_divisor, dd, ds);
    end
    for (int i = 0; i < lat; i++) begin
      @(negedge clk);
      if (bus.div_fetch || bus.resp_valid || bus.req_ready) extra++;
    end
    vectors++;
    if (extra !== 0 || bus.div_dividend !== dd ||
        bus.div_divisor !== ds) begin
      miscompares++;
      $display("FAIL %s wait got extra=%0d ops=%h/%h want 0/%h/%h",
               name, extra, bus.div_dividend, bus.div_divisor, dd, ds);
    end
    bus.div_ready     = 1'b1;
    bus.div_quotient  = q;
    bus.div_remainder = r;
    @(negedge clk);
    bus.div_ready = 1'b0;
    vectors++;
    if (bus.resp_valid !== 1'b1 || bus.resp_result !== res ||
        bus.req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL %s resp got v=%b r=%h rdy=%b want 1/%h/1", name,
               bus.resp_valid, bus.resp_result, bus.req_ready, res);
    end
    @(negedge clk);
    vectors++;
    if (bus.resp_valid !== 1'b0 || bus.resp_result !== res) begin
      miscompares++;
      $display("FAIL %s hold got v=%b r=%h want 0/%h", name,
               bus.resp_valid, bus.resp_result, res);
    end
  endtask

  task automatic do_special(input logic [1:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] res,
                            input string name);
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
    bus.req_valid = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b0;
    vectors++;
    if (bus.resp_valid !== 1'b1 || bus.resp_result !== res) begin
      miscompares++;
      $display("FAIL %s resp got v=%b r=%h want 1/%h", name,
               bus.resp_valid, bus.resp_result, res);
    end
    vectors++;
    if (bus.div_fetch !== 1'b0 || bus.req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL %s fetch/ready got %b/%b want 0/1", name,
               bus.div_fetch, bus.req_ready);
    end
    @(negedge clk);
    vectors++;
    if (bus.resp_valid !== 1'b0 || bus.div_fetch !== 1'b0) begin
      miscompares++;
      $display("FAIL %s after got v=%b f=%b want 0/0", name,
               bus.resp_valid, bus.div_fetch);
    end
  endtask

  task automatic test_unsigned();
    do_normal(2'b01, 32'd100, 32'd7, 32'd100, 32'd7,
              32'd14, 32'd2, 32'd14, 34, "divu_100_7");
    do_normal(2'b11, 32'd100, 32'd7, 32'd100, 32'd7,
              32'd14, 32'd2, 32'd2, 5, "remu_100_7");
    do_normal(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000,
              32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 32'h0, 3,
              "divu_min_m1");
  endtask

  task automatic test_signed();
    do_normal(2'b00, 32'hFFFF_FFF9, 32'd2, 32'd7, 32'd2,
              32'd3, 32'd1, 32'hFFFF_FFFD, 4, "div_m7_2");
    do_normal(2'b10, 32'hFFFF_FFF9, 32'd2, 32'd7, 32'd2,
              32'd3, 32'd1, 32'hFFFF_FFFF, 4, "rem_m7_2");
    do_normal(2'b00, 32'd7, 32'hFFFF_FFFE, 32'd7, 32'd2,
              32'd3, 32'd1, 32'hFFFF_FFFD, 2, "div_7_m2");
    do_normal(2'b10, 32'd7, 32'hFFFF_FFFE, 32'd7, 32'd2,
              32'd3, 32'd1, 32'd1, 2, "rem_7_m2");
  endtask

  task automatic test_div_zero();
    do_special(2'b00, 32'd5, 32'd0, 32'hFFFF_FFFF, "div_5_0");
    do_special(2'b11, 32'd5, 32'd0, 32'd5, "remu_5_0");
    do_special(2'b10, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, "rem_m7_0");
  endtask

  task automatic test_overflow();
    do_special(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000,
               "div_ovf");
    do_special(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, "rem_ovf");
  endtask

  task automatic test_kill();
    int bad;
    bad = 0;
    bus.req_op    = 2'b01;
    bus.req_a     = 32'd1000;
    bus.req_b     = 32'd3;
    bus.req_valid = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b0;
    for (int i = 1; i <= 34; i++) begin
      if (i == 10) bus.req_kill = 1'b1;
      if (bus.resp_valid || bus.req_ready) bad++;
      @(negedge clk);
      bus.req_kill = 1'b0;
    end
    if (bus.resp_valid || bus.req_ready) bad++;
    vectors++;
    if (bad !== 0) begin
      miscompares++;
      $display("FAIL kill_drain got %0d bad cycles want 0", bad);
    end
    bus.div_ready     = 1'b1;
    bus.div_quotient  = 32'd333;
    bus.div_remainder = 32'd1;
    @(negedge clk);
    bus.div_ready = 1'b0;
    vectors++;
    if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL kill_done got v=%b rdy=%b want 0/1",
               bus.resp_valid, bus.req_ready);
    end
    do_normal(2'b01, 32'd9, 32'd3, 32'd9, 32'd3,
              32'd3, 32'd0, 32'd3, 34, "divu_9_3");
  endtask

  task automatic test_kill_fetch();
    bus.req_op    = 2'b01;
    bus.req_a     = 32'd50;
    bus.req_b     = 32'd5;
    bus.req_valid = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_kill  = 1'b1;
    @(negedge clk);
    bus.req_kill = 1'b0;
    vectors++;
    if (bus.req_ready !== 1'b0 || bus.div_fetch !== 1'b0) begin
      miscompares++;
      $display("FAIL kill_fetch_drain got rdy=%b f=%b want 0/0",
               bus.req_ready, bus.div_fetch);
    end
    repeat (3) @(negedge clk);
    bus.div_ready    = 1'b1;
    bus.div_quotient = 32'd10;
    @(negedge clk);
    bus.div_ready = 1'b0;
    vectors++;
    if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL kill_fetch_done got v=%b rdy=%b want 0/1",
               bus.resp_valid, bus.req_ready);
    end
  endtask

  task automatic test_kill_same_cycle();
    bus.req_op    = 2'b00;
    bus.req_a     = 32'd5;
    bus.req_b     = 32'd0;
    bus.req_valid = 1'b1;
    bus.req_kill  = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_kill  = 1'b0;
    vectors++;
    if (bus.resp_valid !== 1'b0 || bus.div_fetch !== 1'b0 ||
        bus.req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL kill_same got v=%b f=%b rdy=%b want 0/0/1",
               bus.resp_valid, bus.div_fetch, bus.req_ready);
    end
  endtask

  task automatic test_back_to_back();
    bus.req_op    = 2'b01;
    bus.req_a     = 32'd100;
    bus.req_b     = 32'd7;
    bus.req_valid = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b0;
    repeat (3) @(negedge clk);
    bus.div_ready     = 1'b1;
    bus.div_quotient  = 32'd14;
    bus.div_remainder = 32'd2;
    @(negedge clk);
    bus.div_ready = 1'b0;
    vectors++;
    if (bus.resp_valid !== 1'b1 || bus.resp_result !== 32'd14 ||
        bus.req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_first got v=%b r=%h rdy=%b want 1/0000000e/1",
               bus.resp_valid, bus.resp_result, bus.req_ready);
    end
    bus.req_op    = 2'b11;
    bus.req_a     = 32'd5;
    bus.req_b     = 32'd0;
    bus.req_valid = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b0;
    vectors++;
    if (bus.resp_valid !== 1'b1 || bus.resp_result !== 32'd5) begin
      miscompares++;
      $display("FAIL b2b_second got v=%b r=%h want 1/00000005",
               bus.resp_valid, bus.resp_result);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_wait();
    bus.req_op    = 2'b01;
    bus.req_a     = 32'd1000;
    bus.req_b     = 32'd3;
    bus.req_valid = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if (bus.div_fetch !== 1'b0 || bus.div_dividend !== 32'h0 ||
        bus.div_divisor !== 32'h0 || bus.resp_valid !== 1'b0 ||
        bus.resp_result !== 32'h0 || bus.req_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL midrst got f=%b dd=%h ds=%h v=%b r=%h rdy=%b",
               bus.div_fetch, bus.div_dividend, bus.div_divisor,
               bus.resp_valid, bus.resp_result, bus.req_ready);
    end
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (bus.req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL midrst_ready got %b want 1", bus.req_ready);
    end
    bus.div_ready    = 1'b1;
    bus.div_quotient = 32'd333;
    @(negedge clk);
    bus.div_ready = 1'b0;
    vectors++;
    if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1 ||
        bus.resp_result !== 32'h0) begin
      miscompares++;
      $display("FAIL stale_ready got v=%b rdy=%b r=%h want 0/1/0",
               bus.resp_valid, bus.req_ready, bus.resp_result);
    end
  endtask

  initial begin
    vectors                  = 0;
    miscompares              = 0;
    rst                      = 1'b1;
    bus.req_valid            = 1'b0;
    bus.req_op               = 2'b00;
    bus.req_a                = 32'h0;
    bus.req_b                = 32'h0;
    bus.req_kill             = 1'b0;
    bus.div_ready            = 1'b0;
    bus.div_division_by_zero = 1'b0;
    bus.div_quotient         = 32'h0;
    bus.div_remainder        = 32'h0;
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_overflow();
    test_kill();
    test_kill_fetch();
    test_kill_same_cycle();
    test_back_to_back();
    test_reset_mid_wait();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/armleocpu_div_sequencer.md
# armleocpu_div_sequencer

Front-end for the iterative unsigned divider that implements the RISC-V M-extension DIV/DIVU/REM/REMU operations. It accepts one request at a time from the execute stage and handles signed/unsigned operand conversion and the RISC-V special cases (divide by zero, signed overflow) locally. It drives the divider's `fetch`/`ready` handshake as initiator, applies sign correction to the result and returns it with a one-cycle valid pulse. It sits between the execute-stage ALU mux and the unsigned divider instance; the divider's ports connect 1:1 to the `div_*` ports.

## Interface
Parameters: none (datapath fixed at 32 bits).

- `clk` in 1: single clock, all state on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: high only in IDLE and not in reset; handshake when `req_valid & req_ready`.
- `req_op` in 2: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- `req_a` in 32: dividend (rs1).
- `req_b` in 32: divisor (rs2).
- `req_kill` in 1: pipeline flush; abandon current request.
- `resp_valid` out 1: one-cycle pulse, result valid.
- `resp_result` out 32: result; holds value until next response.
- `div_fetch` out 1: start pulse to the divider.
- `div_dividend` out 32: unsigned dividend to the divider.
- `div_divisor` out 32: unsigned divisor to the divider.
- `div_ready` in 1: divider done pulse.
- `div_division_by_zero` in 1: divider zero-divisor flag.
- `div_quotient` in 32: divider quotient, valid with `div_ready`.
- `div_remainder` in 32: divider remainder, valid with `div_ready`.

## Operation
- States: IDLE, WAIT, DRAIN.
- Reset values: state IDLE, `resp_valid` 0, `resp_result` 0, `div_fetch` 0, `div_dividend` 0, `div_divisor` 0.
- IDLE, accepting a request with `req_kill` low: latch op, sign_a = `req_a[31]`, sign_b = `req_b[31]` for signed ops, 0 otherwise.
  - `req_b` == 0: next cycle `resp_valid`=1. Result 0xFFFFFFFF for DIV/DIVU, `req_a` for REM/REMU. No `div_fetch`. Stay IDLE.
  - Signed op with `req_a`=0x80000000 and `req_b`=0xFFFFFFFF: next cycle `resp_valid`=1. Result 0x80000000 for DIV, 0 for REM. No `div_fetch`. Stay IDLE.
  - Otherwise: register `div_dividend`=|a| and `div_divisor`=|b|, using two's-complement magnitude when the sign bit is set for signed ops and raw operands for unsigned ops. `div_fetch`=1 for exactly the next cycle. Go to WAIT.
- WAIT, on `div_ready`=1:
  - Select `div_quotient` for DIV/DIVU or `div_remainder` for REM/REMU.
  - Negate the quotient if sign_a^sign_b; negate the remainder if sign_a.
  - Register the value into `resp_result`, pulse `resp_valid` the next cycle, go to IDLE.
  - If `div_division_by_zero`=1 (never expected), return the zero-divisor result instead.
- `div_dividend`/`div_divisor` remain stable from the fetch cycle until `div_ready`.
- Kill rules:
  - `req_kill` in WAIT: go to DRAIN. This includes the cycle in which `div_fetch` is high.
  - DRAIN: wait for `div_ready`, discard the result, go to IDLE. No `resp_valid`.
  - `req_kill` and `req_valid` in the same IDLE cycle: kill wins and the request is not accepted.
  - A special-case response already registered still pulses `resp_valid`; kill has no effect on an already-emitted pulse.
- `div_ready` in IDLE is ignored. This covers a stale divider completion after reset.
- Reset in any state returns to IDLE immediately. The divider shares `rst` via an inverted connection to its `rst_n`.

## Timing
- Special cases: accept at cycle N -> `resp_valid` at N+1.
- Normal path: accept at N, `div_fetch` at N+1, `div_ready` at N+1+L, `resp_valid` at N+2+L.
  - L is the divider latency, 34 cycles for the current divider.
  - The sequencer does not rely on L.
- `req_ready` is low from N+1 until the cycle after `div_ready` (or after the drain completes).
- Back-to-back: a new request can be accepted in the cycle `resp_valid` is high.
- `req_ready` is combinational from state and `rst` only. It does not depend on `req_valid`.

## Test plan
- DIVU 100/7 -> `div_dividend`=100, `div_divisor`=7, one `div_fetch` pulse, result 14. REMU 100/7 -> 2. Check `resp_valid` exactly one cycle after `div_ready`.
- DIV 0xFFFFFFF9(-7)/2 -> divider sees 7/2, result 0xFFFFFFFD. REM same operands -> 0xFFFFFFFF. DIV 7/0xFFFFFFFE -> 0xFFFFFFFD.
- DIV 5/0 -> 0xFFFFFFFF at N+1. REMU 5/0 -> 5 at N+1. `div_fetch` never asserted.
- DIV 0x80000000/0xFFFFFFFF -> 0x80000000. REM same operands -> 0. Both at N+1, no `div_fetch`.
- DIVU 1000/3 then `req_kill` 10 cycles later -> no `resp_valid`, `req_ready` low until `div_ready`. Then DIVU 9/3 -> 3 with correct latency.
- Assert `rst` mid-WAIT, then release -> all outputs at reset values, `req_ready`=1 the cycle after release. A stale `div_ready` injected in IDLE produces no `resp_valid`.
